rgd_arbiter: RTL
================

RGD_ARBITER -- requirements
Module: rgd_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of request/grant/done channels (legal 2..16).
REQ-002 SHALL have parameter MODE, default ARB_RR, meaning arbitration policy: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth on in_req/in_done (legal 2..4).
REQ-004 SHALL have parameter PHASE_INIT, default '0, meaning N_CH-bit reset phase of out_req and of the done phase tracking.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_req, input, N_CH, per-channel two-phase request (toggle = new request), asynchronous to clk.
REQ-009 SHALL have port out_req, output, N_CH, per-channel two-phase grant (toggle = grant issued).
REQ-010 SHALL have port in_done, input, N_CH, per-channel two-phase completion (toggle = resource released), asynchronous to clk.
REQ-011 SHALL have port busy, output, 1, high while any grant is outstanding.
REQ-012 SHALL have port grant_id, output, $clog2(N_CH), index of the current or last granted channel.
REQ-013 SHALL have port proto_err, output, 1, sticky protocol-violation flag.

Function
REQ-014 SHALL synchronise in_req and in_done through SYNC_STAGES flops before use; all latencies below count from the synchronised value.
REQ-015 SHALL treat channel i as pending when sync in_req[i] != out_req[i].
REQ-016 SHALL implement states IDLE, GRANT and RELEASE.
REQ-017 IDLE: with at least one pending channel, SHALL select a winner, toggle out_req[winner], load grant_id, assert busy and enter GRANT in the same clock edge (1-cycle latency).
REQ-018 GRANT: SHALL hold until sync in_done[grant_id] == out_req[grant_id], then enter RELEASE.
REQ-019 RELEASE: SHALL deassert busy, update the round-robin pointer to grant_id+1 modulo N_CH (wrapping from N_CH-1 to 0), and return to IDLE; next grant is no earlier than the cycle after RELEASE.
REQ-020 ARB_RR SHALL choose the first pending channel at or after the pointer, searching upward with wrap; ARB_FIXED SHALL choose the lowest pending index and ignore the pointer.
REQ-021 At most one out_req bit SHALL toggle per cycle, and at most one grant SHALL be outstanding at any time (mutual exclusion).
REQ-022 A request toggle on the granted channel during GRANT SHALL remain pending and be arbitrated after RELEASE.
REQ-023 A done toggle on any channel that holds no outstanding grant SHALL set proto_err; that toggle SHALL otherwise be ignored.
REQ-024 A double request toggle (req returns to the out_req value) before grant SHALL cancel the request silently.
REQ-025 Simultaneous requests in the same cycle SHALL be resolved by REQ-020 with no lost request.

Reset
REQ-026 On rst_n low, SHALL asynchronously set out_req=PHASE_INIT, synchroniser flops=PHASE_INIT, state=IDLE, pointer=0, grant_id=0, busy=0, proto_err=0.
REQ-027 Reset asserted mid-GRANT SHALL abandon the grant with no further out_req toggle; channels SHALL re-handshake from PHASE_INIT.
REQ-028 proto_err SHALL clear only on reset.

Structure
REQ-029 A shared package rgd_arb_pkg SHALL hold the state enum (IDLE/GRANT/RELEASE) and the mode enum (ARB_RR/ARB_FIXED).
REQ-030 Synchronisation SHALL be one sub-module, phase_sync (N-bit, SYNC_STAGES deep, reset value parameter), instantiated twice.

Verification
REQ-031 N_CH=4, RR: toggle in_req[2] only -> out_req[2] toggles SYNC_STAGES+1 cycles later, grant_id=2, busy=1; done[2] toggle -> busy=0 two cycles after sync.
REQ-032 RR: toggle in_req[0..3] in the same cycle -> grant order 0,1,2,3, then repeated requests on 3 and 0 -> 0 then 3 (pointer wrap from 3 to 0).
REQ-033 ARB_FIXED: channels 1 and 3 pending, channel 1 re-requests after each done -> channel 1 always wins, 3 starved.
REQ-034 Toggle in_done[1] while channel 0 is granted -> proto_err=1 and stays 1; channel 0 grant unaffected.
REQ-035 Assert rst_n low during GRANT of channel 2 with PHASE_INIT=4'b0101 -> out_req=4'b0101, busy=0, grant_id=0, proto_err=0 immediately.
REQ-036 Scoreboard on all runs: never more than one outstanding grant; every request toggle is granted exactly once.

Source files
------------

// File: rtl/rgd_arb_pkg.sv
// Shared types and helpers for the rgd_arbiter two-phase request/grant/done arbiter.
package rgd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Both operands are already below n, so one conditional subtract replaces a modulo.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/phase_sync.sv
// N-bit multi-flop synchroniser for two-phase handshake signals crossing into clk.
module phase_sync #(
  parameter int unsigned N       = 4,
  parameter int unsigned STAGES  = 2,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [STAGES-1:0][N-1:0] sync_q;

  // Shift chain; stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rgd_arbiter.sv
// Arbiter over N_CH two-phase request/grant/done channels; one grant outstanding at a time,
// winner chosen round-robin or by fixed lowest-index priority.
module rgd_arbiter
  import rgd_arb_pkg::*;
#(
  parameter int unsigned     N_CH        = 4,
  parameter arb_mode_e       MODE        = ARB_RR,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] PHASE_INIT  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_req,
  output logic [N_CH-1:0]         out_req,
  input  logic [N_CH-1:0]         in_done,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    proto_err
);

  localparam int unsigned IDW = $clog2(N_CH);

  logic [N_CH-1:0] req_sync_s;
  logic [N_CH-1:0] done_sync_s;
  logic [N_CH-1:0] pending_s;
  logic [N_CH-1:0] done_tgl_s;
  logic [N_CH-1:0] grant_mask_s;
  logic [31:0]     base_s;
  logic [IDW-1:0]  idx_s;
  logic [IDW-1:0]  winner_s;
  logic [IDW-1:0]  next_ptr_s;
  logic            win_valid_s;
  logic            done_hit_s;
  logic            bad_done_s;

  arb_state_e      state_q;
  logic [N_CH-1:0] out_req_q;
  logic [N_CH-1:0] done_seen_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  grant_id_q;
  logic            busy_q;
  logic            proto_err_q;

  phase_sync #(
    .N       (N_CH),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (PHASE_INIT)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (in_req),
    .q_o   (req_sync_s)
  );

  phase_sync #(
    .N       (N_CH),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (PHASE_INIT)
  ) u_done_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (in_done),
    .q_o   (done_sync_s)
  );

  // Winner search: scan upward from the pointer (or from 0 in fixed mode), first pending wins.
  always_comb begin
    pending_s   = req_sync_s ^ out_req_q;
    base_s      = (MODE == ARB_FIXED) ? 32'd0 : 32'(ptr_q);
    winner_s    = '0;
    win_valid_s = 1'b0;
    idx_s       = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx_s       = IDW'(wrap_add(base_s, k, N_CH));
      winner_s    = (!win_valid_s && pending_s[idx_s]) ? idx_s : winner_s;
      win_valid_s = win_valid_s | pending_s[idx_s];
    end
  end

  // Done edges are judged against the last sampled phase, so a stray toggle never
  // corrupts the completion test of a later grant on that channel.
  always_comb begin
    done_tgl_s   = done_sync_s ^ done_seen_q;
    grant_mask_s = '0;
    if (state_q == GRANT) begin
      grant_mask_s[grant_id_q] = 1'b1;
    end else begin
      grant_mask_s = '0;
    end
    done_hit_s = |(done_tgl_s & grant_mask_s);
    bad_done_s = |(done_tgl_s & ~grant_mask_s);
    next_ptr_s = (grant_id_q == IDW'(N_CH - 1)) ? '0 : (grant_id_q + IDW'(1));
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_req_q   <= PHASE_INIT;
      done_seen_q <= PHASE_INIT;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      done_seen_q <= done_sync_s;
      if (bad_done_s) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (win_valid_s) begin
            out_req_q[winner_s] <= ~out_req_q[winner_s];
            grant_id_q          <= winner_s;
            busy_q              <= 1'b1;
            state_q             <= GRANT;
          end
        end
        GRANT: begin
          if (done_hit_s) begin
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          busy_q  <= 1'b0;
          ptr_q   <= next_ptr_s;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_req   = out_req_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign proto_err = proto_err_q;

endmodule
